aes_dec_round_ctrl: RTL
=======================

# aes_dec_round_ctrl

Sequencing controller for the AES-128 decryption datapath. It walks the shared 128-bit state register through the inverse cipher: initial AddRoundKey, then NUM_ROUNDS-1 rounds of InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns, then a final round with no InvMixColumns. It drives the round-key index consumed by the registered round-key XOR unit, the state-mux operation select and the state write enable, and completes a Start/Done handshake with the top level.

## Interface
Parameters:
- NUM_ROUNDS, default 10: number of cipher rounds; legal range 2..15; Round output is 4 bits.

Ports:
- Clk  in  1  the single clock; every register updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  level request; sampled only in IDLE.
- KeyReady  in  1  key schedule fully expanded; sampled only in IDLE.
- Round  out  4  round-key index for the XOR unit (0 = first key used in decryption).
- OpSel  out  3  state-mux select: HOLD=0, LOAD=1, ADDKEY=2, ISHIFT=3, ISUB=4, IMIX=5.
- WordSel  out  2  InvMixColumns column index (see Configuration).
- StateWe  out  1  state-register write enable.
- Busy  out  1  high in every state except IDLE and DONE.
- Done  out  1  high only in DONE.

## Operation
- States: IDLE, LOAD, KEY_ISSUE, KEY_CAPTURE, ISHIFT, ISUB, IMIX, DONE.
- IDLE -> LOAD when Start=1 and KeyReady=1. Otherwise stay in IDLE.
- LOAD: OpSel=LOAD, StateWe=1, round counter cleared to 0. Next state is KEY_ISSUE.
- KEY_ISSUE: OpSel=ADDKEY, StateWe=0, so the registered XOR unit captures state^key[Round]. Next state is KEY_CAPTURE.
- KEY_CAPTURE: OpSel=ADDKEY, StateWe=1. Next state:
  - if Round=NUM_ROUNDS: DONE;
  - else if Round=0: increment Round, go to ISHIFT;
  - else: IMIX.
- ISHIFT: OpSel=ISHIFT, StateWe=1, then ISUB.
- ISUB: OpSel=ISUB, StateWe=1, then KEY_ISSUE.
- IMIX: OpSel=IMIX, StateWe=1. On its last cycle, increment Round and go to ISHIFT.
- DONE: Done=1, OpSel=HOLD, StateWe=0. Go to IDLE when Start=0; while Start=1, hold DONE.
- Round stays constant from KEY_ISSUE through KEY_CAPTURE. It only ever increments at the two points above and never exceeds NUM_ROUNDS.
- KeyReady and Start are ignored outside IDLE and DONE; a deasserted KeyReady mid-run does not abort.
- Outputs are Moore functions of state and counters only; there are no combinational paths from inputs.

## Timing
- Reset (checked at a clock edge, takes priority over everything): state=IDLE, Round=0, WordSel=0, OpSel=HOLD, StateWe=0, Busy=0, Done=0.
- Reset asserted mid-run reaches IDLE at the next edge. No cleanup cycles; the state register contents are left untouched.
- Start accepted at edge E gives LOAD in cycle E+1.
- Length of one decryption (macro off) is 3 + 5·(NUM_ROUNDS-1) + 4 cycles. For NUM_ROUNDS=10 that is 52 busy cycles, with Done first high 52 cycles after LOAD begins.
- Length with the macro on is 3 + 8·(NUM_ROUNDS-1) + 4 cycles. For NUM_ROUNDS=10 that is 79.
- Back-to-back runs: at least one IDLE cycle between Done and the next LOAD, because Start must drop first.

## Configuration
- AES_DEC_WORDMIX_EN defined: IMIX lasts 4 cycles.
  - WordSel counts 0,1,2,3, and StateWe=1 each cycle so that one 32-bit column is updated per cycle.
  - The Round increment happens on the WordSel=3 cycle.
- Undefined: IMIX lasts 1 cycle and WordSel is constant 0.

## Structure
- Shared package aes_dec_pkg holds:
  - the state enum;
  - the OpSel enum (values as above);
  - the constant MIX_CYCLES, derived from the macro as 4 or 1.
- Sub-module dec_round_counter: 4-bit counter with synchronous clear and increment, plus a terminal flag (count==NUM_ROUNDS). Its reset value is 0.
- The FSM and the WordSel counter live in aes_dec_round_ctrl.

## Test plan
- Reset check: assert Reset for 2 cycles mid-run (Round=5).
  - Next cycle: IDLE, Round=0, OpSel=0, StateWe=0, Busy=0, Done=0.
- Nominal run, macro off: KeyReady=1, Start=1.
  - Trace is LOAD, then Round 0 ADDKEY (2 cycles), then Round 1 ISHIFT…
  - Done rises exactly 52 cycles after LOAD with Round=10.
  - Count of StateWe=1 cycles is 1+1+9·4+3 = 41.
- Gating: Start=1 with KeyReady=0 for 20 cycles keeps the block in IDLE. Raising KeyReady gives LOAD on the next cycle.
- Handshake: hold Start=1 after Done. Done stays 1 and Busy stays 0. Drop Start, and the block returns to IDLE after one edge; re-asserting Start starts a fresh run with Round=0.
- Macro on: the WordSel sequence in each IMIX is 0,1,2,3, and Round increments on the cycle after WordSel=3. Done arrives 79 cycles after LOAD.
- Key-index ordering: log Round on every KEY_CAPTURE cycle.
  - Expected sequence: 0,1,…,10.
  - Check there is no IMIX after Round=10 and no ISHIFT/ISUB before Round 0's key.

Source files
------------

// File: rtl/aes_dec_pkg.sv
// Shared definitions for the AES-128 decryption round controller.
// Optional feature macro: AES_DEC_WORDMIX_EN (column-serial InvMixColumns,
// four IMIX cycles per round instead of one).
package aes_dec_pkg;

    // FSM state encoding.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE        = 3'd0;
    localparam state_t ST_LOAD        = 3'd1;
    localparam state_t ST_KEY_ISSUE   = 3'd2;
    localparam state_t ST_KEY_CAPTURE = 3'd3;
    localparam state_t ST_ISHIFT      = 3'd4;
    localparam state_t ST_ISUB        = 3'd5;
    localparam state_t ST_IMIX        = 3'd6;
    localparam state_t ST_DONE        = 3'd7;

    // State-mux operation select seen by the datapath.
    typedef enum logic [2:0] {
        OP_HOLD   = 3'd0,
        OP_LOAD   = 3'd1,
        OP_ADDKEY = 3'd2,
        OP_ISHIFT = 3'd3,
        OP_ISUB   = 3'd4,
        OP_IMIX   = 3'd5
    } op_e;

    // Number of cycles spent in IMIX per round.
`ifdef AES_DEC_WORDMIX_EN
    localparam int MIX_CYCLES = 4;
`else
    localparam int MIX_CYCLES = 1;
`endif

endpackage

// File: rtl/dec_round_counter.sv
// Round-key index counter: synchronous clear, saturating increment and a
// terminal flag raised when the count equals NUM_ROUNDS.
module dec_round_counter #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [3:0] count_o,
    output logic       term_o
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    assign term_o  = (count_q == 4'(NUM_ROUNDS));
    assign count_o = count_q;

    // Next count: clear wins; increment never moves past the last round.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = 4'd0;
        end else if (inc_i && !term_o) begin
            count_d = count_q + 4'd1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/aes_dec_round_ctrl.sv
// Sequencing FSM for the AES-128 inverse cipher datapath.
// Handshake: Start is a level request sampled only in IDLE (together with
// KeyReady) and in DONE; Done stays high until Start is dropped, so every
// run is separated from the next by at least one IDLE cycle.
// Optional feature macro: AES_DEC_WORDMIX_EN (column-serial InvMixColumns
// with WordSel stepping 0..3).
module aes_dec_round_ctrl
    import aes_dec_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       KeyReady,
    output logic [3:0] Round,
    output logic [2:0] OpSel,
    output logic [1:0] WordSel,
    output logic       StateWe,
    output logic       Busy,
    output logic       Done
);

    state_t state_q;
    state_t state_d;

    logic   rnd_clr;
    logic   rnd_inc;
    logic   rnd_term;
    logic   mix_last;
    op_e    op;

    dec_round_counter #(
        .NUM_ROUNDS(NUM_ROUNDS)
    ) u_round_cnt (
        .Clk    (Clk),
        .Reset  (Reset),
        .clr_i  (rnd_clr),
        .inc_i  (rnd_inc),
        .count_o(Round),
        .term_o (rnd_term)
    );

`ifdef AES_DEC_WORDMIX_EN
    logic [1:0] word_q;
    logic [1:0] word_d;

    assign mix_last = (word_q == 2'(MIX_CYCLES - 1));
    assign WordSel  = word_q;

    // Column index steps through IMIX and parks at 0 everywhere else.
    always_comb begin
        word_d = 2'd0;
        if (state_q == ST_IMIX && !mix_last) begin
            word_d = word_q + 2'd1;
        end
    end

    // Column index register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            word_q <= 2'd0;
        end else begin
            word_q <= word_d;
        end
    end
`else
    assign mix_last = 1'b1;
    assign WordSel  = 2'd0;
`endif

    // Next-state and round-counter control. The counter is held at zero
    // while idle so the LOAD cycle already presents key index 0.
    always_comb begin
        state_d = state_q;
        rnd_clr = 1'b0;
        rnd_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rnd_clr = 1'b1;
                if (Start && KeyReady) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                rnd_clr = 1'b1;
                state_d = ST_KEY_ISSUE;
            end
            ST_KEY_ISSUE: begin
                state_d = ST_KEY_CAPTURE;
            end
            ST_KEY_CAPTURE: begin
                if (rnd_term) begin
                    state_d = ST_DONE;
                end else if (Round == 4'd0) begin
                    // Initial AddRoundKey is not followed by InvMixColumns.
                    rnd_inc = 1'b1;
                    state_d = ST_ISHIFT;
                end else begin
                    state_d = ST_IMIX;
                end
            end
            ST_ISHIFT: begin
                state_d = ST_ISUB;
            end
            ST_ISUB: begin
                state_d = ST_KEY_ISSUE;
            end
            ST_IMIX: begin
                if (mix_last) begin
                    rnd_inc = 1'b1;
                    state_d = ST_ISHIFT;
                end
            end
            ST_DONE: begin
                if (!Start) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset returns to IDLE at the next edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore output decode from the state register only.
    always_comb begin
        op      = OP_HOLD;
        StateWe = 1'b0;
        Busy    = 1'b1;
        Done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                Busy = 1'b0;
            end
            ST_LOAD: begin
                op      = OP_LOAD;
                StateWe = 1'b1;
            end
            ST_KEY_ISSUE: begin
                op = OP_ADDKEY;
            end
            ST_KEY_CAPTURE: begin
                op      = OP_ADDKEY;
                StateWe = 1'b1;
            end
            ST_ISHIFT: begin
                op      = OP_ISHIFT;
                StateWe = 1'b1;
            end
            ST_ISUB: begin
                op      = OP_ISUB;
                StateWe = 1'b1;
            end
            ST_IMIX: begin
                op      = OP_IMIX;
                StateWe = 1'b1;
            end
            ST_DONE: begin
                Busy = 1'b0;
                Done = 1'b1;
            end
            default: begin
                Busy = 1'b0;
            end
        endcase
    end

    assign OpSel = op;

endmodule
